// File: rtl/alu_pkg.sv
// Shared definitions for the Jac1-8 sequential ALU.
// Opcodes, status bit positions and controller states.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int NUM_ST = 3;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_ADC = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_SBC = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
    localparam logic [3:0] OP_INC = 4'hA;
    localparam logic [3:0] OP_DEC = 4'hB;
    localparam logic [3:0] OP_CMP = 4'hC;
    localparam logic [3:0] OP_MUL = 4'hD;

    localparam int ST_C = 0;
    localparam int ST_Z = 1;
    localparam int ST_N = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DONE
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per cycle, LSB first.
// Full 2*DataWidth product is valid when done pulses.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int DataWidth = DATA_W
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic                   load,
    input  logic [DataWidth-1:0]   a,
    input  logic [DataWidth-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [2*DataWidth-1:0] product
);

    localparam int CW = $clog2(DataWidth);

    logic [DataWidth-1:0] mcand;
    logic [CW-1:0]        cnt;
    logic [DataWidth:0]   sum;

    // Upper half accumulates; lower half holds the remaining multiplier bits.
    assign sum = {1'b0, product[2*DataWidth-1:DataWidth]}
               + (product[0] ? {1'b0, mcand} : '0);

    always_ff @(posedge clk) begin
        if (res) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            mcand   <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                mcand   <= a;
                product <= {{DataWidth{1'b0}}, b};
                cnt     <= '0;
                busy    <= 1'b1;
            end else if (busy) begin
                product <= {sum, product[DataWidth-1:1]};
                cnt     <= cnt + 1'b1;
                if (cnt == CW'(DataWidth - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential 8-bit ALU feeding the status register.
// Single-cycle ops finish in EXEC; MUL runs on alu_mul_seq.
module alu_seq
    import alu_pkg::*;
#(
    parameter int DataWidth     = DATA_W,
    parameter int NumStatusBits = NUM_ST
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     start,
    input  logic [3:0]               opcode,
    input  logic [DataWidth-1:0]     op_a,
    input  logic [DataWidth-1:0]     op_b,
    input  logic                     carry_in,
    output logic                     busy,
    output logic                     done,
    output logic [DataWidth-1:0]     result,
    output logic                     res_we,
    output logic [NumStatusBits-1:0] alu_status,
    output logic                     stat_wr_en,
    output logic                     sel_stat_in_alu_decoder,
    output logic                     illegal_op
);

    state_t                   state;
    logic [3:0]               op_q;
    logic [DataWidth-1:0]     a_q;
    logic [DataWidth-1:0]     b_q;
    logic                     cin_q;
    logic [DataWidth:0]       ext;
    logic [DataWidth-1:0]     r;
    logic                     c;
    logic [NumStatusBits-1:0] st;
    logic [NumStatusBits-1:0] mul_st;
    logic                     mul_load;
    logic                     mul_busy;
    logic                     mul_done;
    logic [2*DataWidth-1:0]   product;

    assign mul_load = (state == S_IDLE) && start && (opcode == OP_MUL);

    alu_mul_seq #(.DataWidth(DataWidth)) u_mul (
        .clk     (clk),
        .res     (res),
        .load    (mul_load),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    // Arithmetic runs one bit wide so bit DataWidth is carry or borrow.
    always_comb begin
        ext = '0;
        r   = '0;
        c   = 1'b0;
        unique case (op_q)
            OP_ADD: ext = {1'b0, a_q} + {1'b0, b_q};
            OP_ADC: ext = {1'b0, a_q} + {1'b0, b_q} + (DataWidth+1)'(cin_q);
            OP_SUB,
            OP_CMP: ext = {1'b0, a_q} - {1'b0, b_q};
            OP_SBC: ext = {1'b0, a_q} - {1'b0, b_q} - (DataWidth+1)'(cin_q);
            OP_INC: ext = {1'b0, a_q} + (DataWidth+1)'(1);
            OP_DEC: ext = {1'b0, a_q} - (DataWidth+1)'(1);
            OP_AND: ext = {1'b0, a_q & b_q};
            OP_OR:  ext = {1'b0, a_q | b_q};
            OP_XOR: ext = {1'b0, a_q ^ b_q};
            OP_NOT: ext = {1'b0, ~a_q};
            OP_SHL: ext = {a_q, 1'b0};
            OP_SHR: ext = {a_q[0], 1'b0, a_q[DataWidth-1:1]};
            default: ext = '0;
        endcase
        r = ext[DataWidth-1:0];
        c = ext[DataWidth];
        st       = '0;
        st[ST_C] = c;
        st[ST_Z] = (r == '0);
        st[ST_N] = r[DataWidth-1];
        mul_st       = '0;
        mul_st[ST_C] = |product[2*DataWidth-1:DataWidth];
        mul_st[ST_Z] = (product[DataWidth-1:0] == '0);
        mul_st[ST_N] = product[DataWidth-1];
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state                   <= S_IDLE;
            busy                    <= 1'b0;
            done                    <= 1'b0;
            res_we                  <= 1'b0;
            stat_wr_en              <= 1'b0;
            sel_stat_in_alu_decoder <= 1'b0;
            illegal_op              <= 1'b0;
            result                  <= '0;
            alu_status              <= '0;
            op_q                    <= '0;
            a_q                     <= '0;
            b_q                     <= '0;
            cin_q                   <= 1'b0;
        end else begin
            done                    <= 1'b0;
            res_we                  <= 1'b0;
            stat_wr_en              <= 1'b0;
            sel_stat_in_alu_decoder <= 1'b0;
            illegal_op              <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= opcode;
                        a_q   <= op_a;
                        b_q   <= op_b;
                        cin_q <= carry_in;
                        busy  <= 1'b1;
                        state <= (opcode == OP_MUL) ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (op_q > OP_MUL) begin
                        illegal_op <= 1'b1;
                    end else begin
                        alu_status              <= st;
                        stat_wr_en              <= 1'b1;
                        sel_stat_in_alu_decoder <= 1'b1;
                        if (op_q != OP_CMP) begin
                            result <= r;
                            res_we <= 1'b1;
                        end
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_MUL: begin
                    if (mul_done && !mul_busy) begin
                        result                  <= product[DataWidth-1:0];
                        alu_status              <= mul_st;
                        res_we                  <= 1'b1;
                        stat_wr_en              <= 1'b1;
                        sel_stat_in_alu_decoder <= 1'b1;
                        busy                    <= 1'b0;
                        done                    <= 1'b1;
                        state                   <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed literal cases plus randomized traffic
// checked every cycle against an arithmetic reference model.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       start = 1'b0;
    logic [3:0] opcode = '0;
    logic [7:0] op_a = '0;
    logic [7:0] op_b = '0;
    logic       carry_in = 1'b0;
    logic       busy, done, res_we, stat_wr_en, sel, illegal_op;
    logic [7:0] result;
    logic [2:0] alu_status;

    alu_seq dut (
        .clk                     (clk),
        .res                     (res),
        .start                   (start),
        .opcode                  (opcode),
        .op_a                    (op_a),
        .op_b                    (op_b),
        .carry_in                (carry_in),
        .busy                    (busy),
        .done                    (done),
        .result                  (result),
        .res_we                  (res_we),
        .alu_status              (alu_status),
        .stat_wr_en              (stat_wr_en),
        .sel_stat_in_alu_decoder (sel),
        .illegal_op              (illegal_op)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Model state: held outputs plus the one operation in flight.
    int cur_r = 0, cur_st = 0, p_r = 0, p_st = 0;
    bit p_we = 0, p_sw = 0, p_ill = 0;
    int start_cyc = -100, done_cyc = -100;
    bit chk_en = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic void ref_op(input int op, input int a, input int b,
                                   input int cin, output int r, output int st,
                                   output bit we, output bit sw, output bit ill);
        int c;
        c = 0; r = 0; we = 1; sw = 1; ill = 0;
        case (op)
            0:  begin r = (a + b) % 256; c = (a + b) > 255; end
            1:  begin r = (a + b + cin) % 256; c = (a + b + cin) > 255; end
            2:  begin r = (a - b + 256) % 256; c = a < b; end
            3:  begin r = (a - b - cin + 512) % 256; c = a < b + cin; end
            4:  r = a & b;
            5:  r = a | b;
            6:  r = a ^ b;
            7:  r = 255 - a;
            8:  begin r = (a * 2) % 256; c = a >= 128; end
            9:  begin r = a / 2; c = a % 2; end
            10: begin r = (a + 1) % 256; c = a == 255; end
            11: begin r = (a + 255) % 256; c = a == 0; end
            12: begin r = (a - b + 256) % 256; c = a < b; we = 0; end
            13: begin r = (a * b) % 256; c = (a * b) > 255; end
            default: begin we = 0; sw = 0; ill = 1; end
        endcase
        st = c + 2 * int'(r == 0) + 4 * int'(r >= 128);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            bit d;
            d = (cyc == done_cyc);
            check("busy", busy, int'(cyc > start_cyc && cyc < done_cyc));
            check("done", done, d);
            check("res_we", res_we, d && p_we);
            check("stat_wr_en", stat_wr_en, d && p_sw);
            check("sel_stat", sel, d && p_sw);
            check("illegal_op", illegal_op, d && p_ill);
            check("result", result, cur_r);
            check("alu_status", alu_status, cur_st);
        end
    end

    // One clock of stimulus; the model advances alongside.
    task automatic step(bit s, int op, int a, int b, int cin, bit rst);
        res      = rst;
        start    = s;
        opcode   = op[3:0];
        op_a     = a[7:0];
        op_b     = b[7:0];
        carry_in = cin[0];
        if (!rst && s && cyc > done_cyc) begin
            ref_op(op, a, b, cin, p_r, p_st, p_we, p_sw, p_ill);
            start_cyc = cyc;
            done_cyc  = cyc + ((op == 13) ? 10 : 2);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            cur_r = 0; cur_st = 0;
            start_cyc = -100; done_cyc = -100;
        end else if (cyc == done_cyc) begin
            if (p_we) cur_r = p_r;
            if (p_sw) cur_st = p_st;
        end
    endtask

    task automatic run(string name, int op, int a, int b, int cin,
                       int er, int est, int ewe, int esw, int eill);
        int k, nb, lat;
        bit got;
        k = cyc; nb = 0; got = 0;
        lat = (op == 13) ? 10 : 2;
        step(1, op, a, b, cin, 0);
        for (int i = 0; i < 14 && !got; i++) begin
            if (done) got = 1;
            else begin
                nb += int'(busy);
                step(0, 0, 0, 0, 0, 0);
            end
        end
        check({name, " done_seen"}, got, 1);
        check({name, " latency"}, cyc - k, lat);
        check({name, " busy_cycles"}, nb, lat - 1);
        check({name, " result"}, result, er);
        check({name, " status"}, alu_status, est);
        check({name, " res_we"}, res_we, ewe);
        check({name, " stat_wr_en"}, stat_wr_en, esw);
        check({name, " illegal"}, illegal_op, eill);
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int nd;
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk_en = 1;
        check("reset result", result, 0);
        check("reset status", alu_status, 0);
        check("reset busy", busy, 0);

        run("ADD FF+01", 0, 'hFF, 'h01, 0, 'h00, 3, 1, 1, 0);
        run("SBC 10-01-1", 3, 'h10, 'h01, 1, 'h0E, 0, 1, 1, 0);
        run("SUB 01-02", 2, 'h01, 'h02, 0, 'hFF, 5, 1, 1, 0);
        run("MUL 10*10", 13, 'h10, 'h10, 0, 'h00, 3, 1, 1, 0);
        run("MUL 0F*03", 13, 'h0F, 'h03, 0, 'h2D, 0, 1, 1, 0);
        run("CMP 05,05", 12, 'h05, 'h05, 0, 'h2D, 2, 0, 1, 0);
        run("ILL E", 14, 'h12, 'h34, 0, 'h2D, 2, 0, 0, 1);
        run("INC FF", 10, 'hFF, 0, 0, 'h00, 3, 1, 1, 0);
        run("DEC 00", 11, 'h00, 0, 0, 'hFF, 5, 1, 1, 0);
        run("ADC 7F+0+1", 1, 'h7F, 'h00, 1, 'h80, 4, 1, 1, 0);

        // Starts issued while MUL is busy must be dropped.
        nd = 0;
        step(1, 13, 'h07, 'h09, 0, 0);
        for (int i = 0; i < 14; i++) begin
            step(i < 3, 0, 'h01, 'h01, 0, 0);
            nd += int'(done);
        end
        check("busy-start done count", nd, 1);
        check("busy-start result", result, 'h3F);

        // Reset during the 4th MUL cycle aborts with no done.
        step(1, 13, 'h0F, 'h03, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        check("abort result", result, 0);
        check("abort status", alu_status, 0);
        check("abort busy", busy, 0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0, 0, 0);
            nd += int'(done);
        end
        check("abort no done", nd, 0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 2) == 0, int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 1)), $urandom_range(0, 199) == 0);
        end
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
